// File: rtl/bf_run_ctrl_if.sv
// bf_run_ctrl_if: program byte stream in and stdout byte stream out of bf_run_ctrl.
interface bf_run_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
    modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
endinterface

// File: rtl/bf_run_ctrl.sv
// bf_run_ctrl: loads a program, optionally zeroes data memory (BF_CLEAR_EN), then runs the core
// and buffers its stdout; owns the memory ports except in START/RUN where it mirrors the core.
module bf_run_ctrl #(
    parameter int PROG_ADDR_WIDTH = 8,
    parameter int DATA_ADDR_WIDTH = 8,
    parameter int HALT_CYCLES     = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    bf_run_ctrl_if.slave               io,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic                       cpu_en,
    output logic                       cpu_reset,
    input  logic [PROG_ADDR_WIDTH-1:0] cpu_prog_addr,
    input  logic                       cpu_prog_ren,
    input  logic [DATA_ADDR_WIDTH-1:0] cpu_data_addr,
    input  logic                       cpu_data_wen,
    input  logic                       cpu_data_ren,
    input  logic [7:0]                 cpu_data_wval,
    input  logic [7:0]                 cpu_stdout,
    input  logic                       cpu_stdout_en,
    output logic [PROG_ADDR_WIDTH-1:0] pm_addr,
    output logic                       pm_ren,
    output logic                       pm_wen,
    output logic [7:0]                 pm_wdata,
    output logic [DATA_ADDR_WIDTH-1:0] dm_addr,
    output logic                       dm_ren,
    output logic                       dm_wen,
    output logic [7:0]                 dm_wdata
);
    localparam int PA = PROG_ADDR_WIDTH;
    localparam int DA = DATA_ADDR_WIDTH;
    localparam int HW = $clog2(HALT_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_START, S_RUN, S_DONE} state_t;

`ifdef BF_CLEAR_EN
    localparam state_t LOAD_ENTRY = S_CLEAR;
`else
    localparam state_t LOAD_ENTRY = S_LOAD;
`endif

    state_t        state_q, state_d;
    logic [PA-1:0] ptr_q, ptr_d;
    logic          err_q, err_d;
    logic          cnt_q, cnt_d;
    logic [HW-1:0] halt_q, halt_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    out_data_q, out_data_d;
`ifdef BF_CLEAR_EN
    logic [DA-1:0] clr_q, clr_d;
`endif

    assign err          = err_q;
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        halt_d      = halt_q;
        out_valid_d = out_valid_q && !io.out_ready;
        out_data_d  = out_data_q;
`ifdef BF_CLEAR_EN
        clr_d       = clr_q;
`endif
        busy        = state_q inside {S_CLEAR, S_LOAD, S_START, S_RUN};
        done        = state_q == S_DONE;
        io.in_ready = state_q == S_LOAD;
        cpu_reset   = state_q == S_START;
        // a full buffer the sink is not taking freezes the core so it holds its stdout request
        cpu_en      = !reset && (cpu_reset || (state_q == S_RUN && !(out_valid_q && !io.out_ready)));
        case (state_q)
            S_IDLE, S_DONE: if (start && !out_valid_q) begin
                state_d = LOAD_ENTRY;
                ptr_d   = '0;
                err_d   = 1'b0;
            end
`ifdef BF_CLEAR_EN
            S_CLEAR: begin
                clr_d   = clr_q + DA'(1);
                state_d = &clr_q ? S_LOAD : S_CLEAR;
            end
`endif
            S_LOAD: if (io.in_valid) begin
                ptr_d = ptr_q + PA'(1);
                if (io.in_data == 8'h00) begin
                    state_d = S_START;
                    cnt_d   = 1'b0;
                end else if (&ptr_q) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_START: begin
                cnt_d   = 1'b1;
                halt_d  = '0;
                state_d = cnt_q ? S_RUN : S_START;
            end
            S_RUN: begin
                if (cpu_en && cpu_stdout_en) begin
                    out_valid_d = 1'b1;
                    out_data_d  = cpu_stdout;
                end
                halt_d  = cpu_prog_ren ? '0 : halt_q + HW'(cpu_en);
                state_d = halt_d == HW'(HALT_CYCLES) ? S_DONE : S_RUN;
            end
            default: ;
        endcase
    end

    // kept apart from the FSM process so the core's combinational path through memory never loops back into it
    always_comb begin
        pm_addr  = '0;
        pm_ren   = 1'b0;
        pm_wen   = 1'b0;
        pm_wdata = '0;
        dm_addr  = '0;
        dm_ren   = 1'b0;
        dm_wen   = 1'b0;
        dm_wdata = '0;
        if (state_q == S_START || state_q == S_RUN) begin
            pm_addr  = cpu_prog_addr;
            pm_ren   = cpu_prog_ren;
            dm_addr  = cpu_data_addr;
            dm_ren   = cpu_data_ren;
            dm_wen   = cpu_data_wen;
            dm_wdata = cpu_data_wval;
        end else if (state_q == S_LOAD && io.in_valid) begin
            pm_wen   = 1'b1;
            pm_addr  = ptr_q;
            pm_wdata = &ptr_q ? 8'h00 : io.in_data;
        end
`ifdef BF_CLEAR_EN
        else if (state_q == S_CLEAR) begin
            dm_wen  = 1'b1;
            dm_addr = clr_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            err_q       <= 1'b0;
            cnt_q       <= 1'b0;
            halt_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef BF_CLEAR_EN
            clr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            halt_q      <= halt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
`ifdef BF_CLEAR_EN
            clr_q       <= clr_d;
`endif
        end
    end
endmodule

// File: tb/tb_bf_run_ctrl.sv
// tb_bf_run_ctrl: random brainfuck programs run through bf_run_ctrl with a behavioural core and memories;
// stdout is checked by a scoreboard fed from a direct interpreter of each program.
`timescale 1ns/1ps
module tb_bf_run_ctrl;
    localparam int PA = 4;
    localparam int DA = 4;
    localparam int HC = 8;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    always #5 clk = ~clk;

    bf_run_ctrl_if bus();
    logic          busy, done, err, cpu_en, cpu_reset;
    logic [PA-1:0] cpu_prog_addr, pm_addr;
    logic [DA-1:0] cpu_data_addr, dm_addr;
    logic          cpu_prog_ren, cpu_data_wen, cpu_data_ren, cpu_stdout_en;
    logic [7:0]    cpu_data_wval, cpu_stdout;
    logic          pm_ren, pm_wen, dm_ren, dm_wen;
    logic [7:0]    pm_wdata, dm_wdata;

    bf_run_ctrl #(.PROG_ADDR_WIDTH(PA), .DATA_ADDR_WIDTH(DA), .HALT_CYCLES(HC)) dut (
        .clk(clk), .reset(reset), .start(start), .io(bus),
        .busy(busy), .done(done), .err(err), .cpu_en(cpu_en), .cpu_reset(cpu_reset),
        .cpu_prog_addr(cpu_prog_addr), .cpu_prog_ren(cpu_prog_ren), .cpu_data_addr(cpu_data_addr),
        .cpu_data_wen(cpu_data_wen), .cpu_data_ren(cpu_data_ren), .cpu_data_wval(cpu_data_wval),
        .cpu_stdout(cpu_stdout), .cpu_stdout_en(cpu_stdout_en),
        .pm_addr(pm_addr), .pm_ren(pm_ren), .pm_wen(pm_wen), .pm_wdata(pm_wdata),
        .dm_addr(dm_addr), .dm_ren(dm_ren), .dm_wen(dm_wen), .dm_wdata(dm_wdata)
    );

    int errors = 0, checks = 0;
    logic [7:0] pm [2**PA];
    logic [7:0] dm [2**DA];
    logic [7:0] ref_dm [2**DA];
    logic [7:0] exp_q [$];
    logic       fill = 1'b0, stall = 1'b0;
    logic [7:0] fill_val = 8'h00;
    int         en_cnt = 0, rst_cnt = 0;

    // memories with combinational read
    always @(posedge clk) begin
        if (fill) for (int i = 0; i < 2**DA; i++) dm[i] <= fill_val;
        else if (dm_wen) dm[dm_addr] <= dm_wdata;
        if (fill) for (int i = 0; i < 2**PA; i++) pm[i] <= 8'h00;
        else if (pm_wen) pm[pm_addr] <= pm_wdata;
    end

    // behavioural core: one instruction per enabled cycle, instruction set + - < > . and 0x00 = halt
    logic [PA-1:0] pc = '0;
    logic [DA-1:0] dp = '0;
    logic          halted = 1'b1;
    logic [7:0]    instr, rd;
    assign instr         = pm[pm_addr];
    assign rd            = dm[dm_addr];
    assign cpu_prog_addr = pc;
    assign cpu_prog_ren  = !halted;
    assign cpu_data_addr = dp;
    assign cpu_data_ren  = !halted;
    assign cpu_data_wen  = cpu_en && !cpu_reset && !halted && (instr == "+" || instr == "-");
    assign cpu_data_wval = instr == "+" ? rd + 8'd1 : rd - 8'd1;
    assign cpu_stdout    = rd;
    assign cpu_stdout_en = !cpu_reset && !halted && instr == ".";
    always @(posedge clk) begin
        if (cpu_en) begin
            if (cpu_reset) begin
                pc <= '0;
                dp <= '0;
                halted <= 1'b0;
            end else if (!halted) begin
                if (instr == 8'h00) halted <= 1'b1;
                else pc <= pc + PA'(1);
                if (instr == ">") dp <= dp + DA'(1);
                else if (instr == "<") dp <= dp - DA'(1);
            end
        end
    end

    always @(negedge clk) begin
        if (cpu_en) en_cnt++;
        if (cpu_reset) rst_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1 bus.out_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // scoreboard monitor
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!reset && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_extra: got %0h expected no byte", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_byte", bus.out_data, e);
                end
            end
        end
    end

    // reference: interpret the program directly on a model data memory
    task automatic model_run(input logic [7:0] prog[$]);
        int d = 0;
`ifdef BF_CLEAR_EN
        foreach (ref_dm[i]) ref_dm[i] = 8'h00;
`endif
        for (int i = 0; i < prog.size(); i++) begin
            if (prog[i] == 8'h00) break;
            if (prog[i] == "+") ref_dm[d] = ref_dm[d] + 8'd1;
            else if (prog[i] == "-") ref_dm[d] = ref_dm[d] - 8'd1;
            else if (prog[i] == ">") d = (d + 1) % (2**DA);
            else if (prog[i] == "<") d = (d + 2**DA - 1) % (2**DA);
            else if (prog[i] == ".") exp_q.push_back(ref_dm[d]);
        end
    endtask

    task automatic load(input logic [7:0] prog[$], input bit poke);
        int t;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        foreach (prog[i]) begin
            bus.in_valid = 1'b1;
            bus.in_data  = prog[i];
            start        = poke && i == 1;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!bus.in_ready && t < 1000);
            if (!bus.in_ready) begin
                chk("load_stuck", bus.in_ready, 1);
                bus.in_valid = 1'b0;
                start = 1'b0;
                return;
            end
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
            start = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic run(input logic [7:0] prog[$], input bit ovf, input bit poke, input int stall_cycles);
        int en0 = en_cnt, rs0 = rst_cnt, t = 0, sc = stall_cycles;
        bit en_stall = 1'b0;
        if (!ovf) model_run(prog);
        load(prog, poke);
        while (!(done && !bus.out_valid) && t < 5000) begin
            @(negedge clk);
            t++;
            start = poke && t == 2 && busy;
            if (sc > 0 && bus.out_valid) begin
                if (cpu_en) en_stall = 1'b1;
                sc--;
                if (sc == 0) stall = 1'b0;
            end
        end
        start = 1'b0;
        if (stall_cycles > 0) chk("stall_cpu_en", en_stall, 0);
        chk("done", done, 1);
        chk("err", err, ovf);
        chk("out_pending", exp_q.size(), 0);
        foreach (prog[i]) chk("pm", pm[i], (ovf && i == 2**PA - 1) ? 8'h00 : prog[i]);
        chk("cpu_reset_cycles", rst_cnt - rs0, ovf ? 0 : 2);
        chk("cpu_en_seen", en_cnt > en0, !ovf);
    endtask

    initial begin
        logic [7:0] p[$];
        string ops = "+-<>.+.x";
        int t, len;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        foreach (ref_dm[i]) ref_dm[i] = 8'h00;
        fill = 1'b1;
        repeat (3) @(posedge clk);
        #1 fill = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_cpu_en", cpu_en, 0);
        chk("rst_cpu_reset", cpu_reset, 0);
        chk("rst_mem_ctl", {pm_ren, pm_wen, dm_ren, dm_wen}, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        p = '{"+", "+", "+", ".", 8'h00};
        run(p, 0, 0, 0);

        p = '{"+", ".", "+", ".", 8'h00};
        stall = 1'b1;
        run(p, 0, 0, 100);

        @(posedge clk);
        #1 fill_val = 8'h55;
        fill = 1'b1;
        foreach (ref_dm[i]) ref_dm[i] = 8'h55;
        @(posedge clk);
        #1 fill = 1'b0;
        p = '{".", 8'h00};
        run(p, 0, 0, 0);

        for (int n = 0; n < 20; n++) begin
            len = $urandom_range(1, 14);
            p = {};
            for (int i = 0; i < len; i++) p.push_back(ops[$urandom_range(0, 7)]);
            p.push_back(8'h00);
            run(p, 0, n % 4 == 0, 0);
        end

        p = {};
        for (int i = 0; i < 2**PA; i++) p.push_back("+");
        run(p, 1, 0, 0);
        p = '{"+", ".", 8'h00};
        run(p, 0, 0, 0);

        p = '{".", 8'h00};
        model_run(p);
        stall = 1'b1;
        load(p, 0);
        t = 0;
        while (!bus.out_valid && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("pre_reset_out_valid", bus.out_valid, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_cpu_en", cpu_en, 0);
        chk("mid_rst_mem_ctl", {done, bus.in_ready, pm_ren, dm_ren, dm_wen}, 0);
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        stall = 1'b0;
        p = '{"+", ".", "+", ".", 8'h00};
        run(p, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
